// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and access sequencer for the two-port, byte-addressed, big-endian data memory.
// Each grant runs IDLE -> ACCESS -> RESP, with a range check and registered read data returned on Done.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_BYTES  = 128
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req0,
  input  logic                  Write0,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [DATA_WIDTH-1:0] WData0,
  output logic                  Gnt0,
  output logic                  Done0,
  output logic [DATA_WIDTH-1:0] RData0,
  output logic                  Err0,
  input  logic                  Req1,
  input  logic                  Write1,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Gnt1,
  output logic                  Done1,
  output logic [DATA_WIDTH-1:0] RData1,
  output logic                  Err1,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  typedef enum logic [1:0] {Idle, Access, Resp} stateT;

  localparam logic [ADDR_WIDTH-1:0] MaxAddr = ADDR_WIDTH'(MEM_BYTES - 2);

  stateT                 state;
  logic                  lastPort;
  logic                  latPort;
  logic                  latWrite;
  logic                  latIllegal;
  logic                  pick1;
  logic                  pickWrite;
  logic                  pickIllegal;
  logic [ADDR_WIDTH-1:0] pickAddr;
  logic [DATA_WIDTH-1:0] pickWData;

  // lastPort remembers the most recent grant; on contention the other port wins.
  always_comb begin
    pick1       = Req1 && (!Req0 || !lastPort);
    pickWrite   = pick1 ? Write1 : Write0;
    pickAddr    = pick1 ? Addr1  : Addr0;
    pickWData   = pick1 ? WData1 : WData0;
    pickIllegal = (pickAddr > MaxAddr);
  end

  // The Mem* output registers double as the latched address/data for the ACCESS cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= Idle;
      lastPort     <= 1'b1;
      latPort      <= 1'b0;
      latWrite     <= 1'b0;
      latIllegal   <= 1'b0;
      Gnt0         <= 1'b0;
      Gnt1         <= 1'b0;
      Done0        <= 1'b0;
      Done1        <= 1'b0;
      Err0         <= 1'b0;
      Err1         <= 1'b0;
      RData0       <= '0;
      RData1       <= '0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
    end else begin
      Gnt0  <= 1'b0;
      Gnt1  <= 1'b0;
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      Err0  <= 1'b0;
      Err1  <= 1'b0;
      case (state)
        Idle: begin
          if (Req0 || Req1) begin
            latPort      <= pick1;
            lastPort     <= pick1;
            latWrite     <= pickWrite;
            latIllegal   <= pickIllegal;
            Gnt0         <= !pick1;
            Gnt1         <= pick1;
            MemAddress   <= pickAddr;
            MemWriteData <= pickWData;
            MemWrite     <= pickWrite && !pickIllegal;
            MemRead      <= !pickWrite && !pickIllegal;
            state        <= Access;
          end
        end
        Access: begin
          MemAddress   <= '0;
          MemWriteData <= '0;
          MemWrite     <= 1'b0;
          MemRead      <= 1'b0;
          state        <= Resp;
          // Writes and out-of-range accesses return zero data.
          if (latPort) begin
            Done1  <= 1'b1;
            Err1   <= latIllegal;
            RData1 <= (latWrite || latIllegal) ? '0 : MemReadData;
          end else begin
            Done0  <= 1'b1;
            Err0   <= latIllegal;
            RData0 <= (latWrite || latIllegal) ? '0 : MemReadData;
          end
        end
        Resp: begin
          state <= Idle;
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: byte-array memory model, table-driven vectors,
// a Done scoreboard, and hand sequences for contention and reset during ACCESS.
module tb_data_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0 = 1'b0, Write0 = 1'b0, Req1 = 1'b0, Write1 = 1'b0;
  logic [15:0] Addr0 = '0, WData0 = '0, Addr1 = '0, WData1 = '0;
  logic        Gnt0, Done0, Err0, Gnt1, Done1, Err1;
  logic [15:0] RData0, RData1;
  logic [15:0] MemAddress, MemWriteData, MemReadData;
  logic        MemWrite, MemRead;

  data_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_BYTES(128)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Write0(Write0), .Addr0(Addr0), .WData0(WData0),
    .Gnt0(Gnt0), .Done0(Done0), .RData0(RData0), .Err0(Err0),
    .Req1(Req1), .Write1(Write1), .Addr1(Addr1), .WData1(WData1),
    .Gnt1(Gnt1), .Done1(Done1), .RData1(RData1), .Err1(Err1),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  // Memory model: byte i starts as value i; big-endian word, combinational read.
  logic [7:0] mem [0:127];
  logic       memLoaded = 1'b0;

  always @(posedge Clock) begin
    if (!memLoaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
      memLoaded <= 1'b1;
    end else if (MemWrite && MemAddress <= 16'd126) begin
      mem[MemAddress[6:0]]        <= MemWriteData[15:8];
      mem[MemAddress[6:0] + 7'd1] <= MemWriteData[7:0];
    end
  end

  always_comb begin
    MemReadData = '0;
    if (MemAddress <= 16'd126)
      MemReadData = {mem[MemAddress[6:0]], mem[MemAddress[6:0] + 7'd1]};
  end

  typedef struct {
    logic        port;
    logic [15:0] rdata;
    logic        err;
  } expT;

  typedef struct {
    logic        port;
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRData;
    logic        expErr;
    int          expWr;
    int          expRd;
  } vecT;

  expT sbQ[$];
  vecT vecs[11];
  int  vectors = 0;
  int  miscompares = 0;
  int  wrCount, rdCount;
  int  g0, g1, d0, d1, nGnt, nDone, doneSeen;
  int  gntCyc[4];
  int  doneCyc[4];
  logic [3:0] gntOrder;

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input logic port, input logic [15:0] rdata, input logic err);
    expT e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    sbQ.push_back(e);
  endtask

  task automatic driveReq(input logic port, input logic req, input logic write,
                          input logic [15:0] addr, input logic [15:0] wdata);
    if (port) begin
      Req1 = req; Write1 = write; Addr1 = addr; WData1 = wdata;
    end else begin
      Req0 = req; Write0 = write; Addr0 = addr; WData0 = wdata;
    end
  endtask

  task automatic waitCycle();
    @(negedge Clock);
    if (MemWrite) wrCount++;
    if (MemRead) rdCount++;
  endtask

  task automatic checkResetOutputs(input string name);
    checkVal({name, "Ctrl"}, {24'd0, Gnt0, Gnt1, Done0, Done1, Err0, Err1, MemWrite, MemRead}, 32'd0);
    checkVal({name, "Buses"}, {16'd0, RData0 | RData1 | MemAddress | MemWriteData}, 32'd0);
  endtask

  // One isolated transaction: the requester scrambles its inputs right after Gnt.
  task automatic applyStimulus(input vecT v);
    int k;
    @(negedge Clock);
    driveReq(v.port, 1'b1, v.write, v.addr, v.wdata);
    pushExp(v.port, v.expRData, v.expErr);
    wrCount = 0;
    rdCount = 0;
    k = 0;
    do begin
      waitCycle();
      k++;
    end while (!(v.port ? Gnt1 : Gnt0) && k < 8);
    checkVal("gntLatency", k, 1);
    checkVal("memAddress", {16'd0, MemAddress}, {16'd0, v.addr});
    if (v.write) checkVal("memWriteData", {16'd0, MemWriteData}, {16'd0, v.wdata});
    driveReq(v.port, 1'b0, ~v.write, 16'h0009, 16'h0000);
    k = 0;
    do begin
      waitCycle();
      k++;
    end while (!(v.port ? Done1 : Done0) && k < 8);
    checkVal("doneLatency", k, 1);
    checkVal("memWriteCycles", wrCount, v.expWr);
    checkVal("memReadCycles", rdCount, v.expRd);
  endtask

  // Scoreboard: every Done must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    expT e;
    if (!Reset && (Done0 || Done1)) begin
      checkVal("singleDone", {31'd0, Done0 && Done1}, 32'd0);
      if (sbQ.size() == 0) begin
        checkVal("unexpectedDone", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkVal("donePort", {31'd0, Done1}, {31'd0, e.port});
        checkVal("doneRData", {16'd0, Done1 ? RData1 : RData0}, {16'd0, e.rdata});
        checkVal("doneErr", {31'd0, Done1 ? Err1 : Err0}, {31'd0, e.err});
      end
    end
    if (!Reset && (Gnt0 || Gnt1))
      checkVal("singleGnt", {31'd0, Gnt0 && Gnt1}, 32'd0);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0002, 16'h1234, 16'h0000, 1'b0, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0, 0, 1};
    vecs[2]  = '{1'b1, 1'b1, 16'h007F, 16'hBEEF, 16'h0000, 1'b1, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 16'h007E, 16'h0000, 16'h7E7F, 1'b0, 0, 1};
    vecs[5]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0506, 1'b0, 0, 1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h3404, 1'b0, 0, 1};
    vecs[7]  = '{1'b1, 1'b1, 16'h007E, 16'hCAFE, 16'h0000, 1'b0, 1, 0};
    vecs[8]  = '{1'b0, 1'b0, 16'h007E, 16'h0000, 16'hCAFE, 1'b0, 0, 1};
    vecs[9]  = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0112, 1'b0, 0, 1};
    vecs[10] = '{1'b1, 1'b0, 16'h007F, 16'h0000, 16'h0000, 1'b1, 0, 0};

    #1;
    checkResetOutputs("resetAsserted");
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    checkResetOutputs("idleAfterReset");

    // Simultaneous requests right after reset: port 0 first, port 1 after IDLE.
    driveReq(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    driveReq(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    pushExp(1'b0, 16'h0001, 1'b0);
    pushExp(1'b1, 16'h0001, 1'b0);
    g0 = -1; g1 = -1; d0 = -1; d1 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clock);
      if (Gnt0) begin g0 = k; Req0 = 1'b0; end
      if (Gnt1) begin g1 = k; Req1 = 1'b0; end
      if (Done0) d0 = k;
      if (Done1) d1 = k;
    end
    checkVal("tieGnt0Cycle", g0, 1);
    checkVal("tieDone0Cycle", d0, 2);
    checkVal("tieGnt1Cycle", g1, 4);
    checkVal("tieDone1Cycle", d1, 5);

    // Both requests held for four transactions: strict alternation, 3-cycle spacing.
    driveReq(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    driveReq(1'b1, 1'b1, 1'b0, 16'h007E, 16'h0000);
    pushExp(1'b0, 16'h0001, 1'b0);
    pushExp(1'b1, 16'h7E7F, 1'b0);
    pushExp(1'b0, 16'h0001, 1'b0);
    pushExp(1'b1, 16'h7E7F, 1'b0);
    nGnt = 0; nDone = 0; gntOrder = '0;
    for (int k = 1; k <= 20 && nDone < 4; k++) begin
      @(negedge Clock);
      if ((Gnt0 || Gnt1) && nGnt < 4) begin
        gntOrder[3 - nGnt] = Gnt1;
        gntCyc[nGnt] = k;
        nGnt++;
        if (nGnt == 4) begin Req0 = 1'b0; Req1 = 1'b0; end
      end
      if ((Done0 || Done1) && nDone < 4) begin
        doneCyc[nDone] = k;
        nDone++;
      end
    end
    checkVal("rrGrantCount", nGnt, 4);
    checkVal("rrDoneCount", nDone, 4);
    checkVal("rrGrantOrder", {28'd0, gntOrder}, 32'h5);
    if (nGnt == 4) checkVal("rrFirstGnt", gntCyc[0], 1);
    if (nDone == 4)
      for (int i = 0; i < 3; i++) checkVal("rrDoneSpacing", doneCyc[i + 1] - doneCyc[i], 3);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    checkVal("memByte2", {24'd0, mem[2]}, 32'h12);
    checkVal("memByte3", {24'd0, mem[3]}, 32'h34);
    checkVal("memByte126", {24'd0, mem[126]}, 32'hCA);
    checkVal("memByte127", {24'd0, mem[127]}, 32'hFE);

    // Reset in the middle of a write ACCESS: no write, no Done, back to IDLE.
    @(negedge Clock);
    driveReq(1'b0, 1'b1, 1'b1, 16'h0004, 16'hBEEF);
    @(negedge Clock);
    checkVal("abortGnt0", {31'd0, Gnt0}, 32'd1);
    checkVal("abortMemWrite", {31'd0, MemWrite}, 32'd1);
    #1;
    Reset = 1'b1;
    driveReq(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    checkResetOutputs("abortReset");
    @(negedge Clock);
    Reset = 1'b0;
    doneSeen = 0;
    repeat (3) begin
      @(negedge Clock);
      if (Done0 || Done1) doneSeen++;
    end
    checkVal("abortNoDone", doneSeen, 0);
    checkVal("abortMemByte4", {24'd0, mem[4]}, 32'h04);
    checkVal("abortMemByte5", {24'd0, mem[5]}, 32'h05);
    applyStimulus('{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0405, 1'b0, 0, 1});

    repeat (2) @(negedge Clock);
    checkVal("scoreboardDrain", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-requester controller for the byte-addressed, big-endian 16-bit data memory. It arbitrates round-robin between port 0 (CPU load/store stage) and port 1 (debug/DMA loader), then sequences exactly one memory access per grant. It also range-checks the address and returns registered read data with a one-cycle Done pulse. It sits between the requesters and the data memory and is the only block that drives the memory's Address/WriteData/MemWrite/MemRead.

Parameters:
ADDR_WIDTH, 16, width of request and memory addresses
DATA_WIDTH, 16, width of read/write data (two bytes, big-endian)
MEM_BYTES, 128, memory depth in bytes; the highest legal word address is MEM_BYTES-2

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
Req0  input  1  port 0 request; held high until Gnt0
Write0  input  1  port 0: 1=write, 0=read
Addr0  input  ADDR_WIDTH  port 0 byte address of the word's high byte
WData0  input  DATA_WIDTH  port 0 write data
Gnt0  output  1  one-cycle pulse: port 0 request accepted
Done0  output  1  one-cycle pulse: port 0 access complete
RData0  output  DATA_WIDTH  port 0 read data, valid while Done0=1
Err0  output  1  address out of range, valid while Done0=1
Req1, Write1, Addr1, WData1, Gnt1, Done1, RData1, Err1  same as port 0, for port 1
MemAddress  output  ADDR_WIDTH  to memory Address
MemWriteData  output  DATA_WIDTH  to memory WriteData
MemWrite  output  1  to memory MemWrite
MemRead  output  1  to memory MemRead
MemReadData  input  DATA_WIDTH  from memory ReadData (combinational read)

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE.
  - All outputs are 0: Gnt*, Done*, Err*, RData*, Mem*.
  - The priority pointer favours port 0.
  - The latched request is cleared.
- FSM states are IDLE, ACCESS, RESP.
  - IDLE: if any Req is high, pick the winner (see arbitration), latch its Write/Addr/WData and port id, pulse its Gnt, and go to ACCESS next cycle.
  - ACCESS (1 cycle): drive MemAddress = latched Addr and MemWriteData = latched WData. Assert MemWrite if write, else MemRead. The memory commits the write on the rising edge that ends ACCESS; RData is captured from MemReadData on that same edge. Go to RESP.
  - RESP (1 cycle): pulse Done of the latched port with RData/Err valid, then go to IDLE.
- Timing: Gnt and the ACCESS entry are registered. Req sampled high at edge N gives Gnt high in cycle N+1 (ACCESS) and Done high in cycle N+2. A transaction occupies 3 cycles, so throughput is one access per 3 cycles.
- Arbitration is round-robin.
  - If only one Req is high, that port wins.
  - If both are high, the port not granted last wins; after reset the pointer favours port 0.
  - The pointer updates only on a grant.
- A Req arriving while not in IDLE stays pending; the requester must hold Req, Write, Addr and WData stable until Gnt.
- After Gnt the requester may change its inputs; the controller uses latched values only.
- Range check: the access is illegal if latched Addr > MEM_BYTES-2 (high byte or low byte out of range). For an illegal access:
  - ACCESS still takes its cycle, but MemWrite=MemRead=0.
  - In RESP, Err=1 and RData=0.
- Odd addresses are legal (byte-addressed, no alignment check).
- RData holds its last value outside Done, except it is cleared by reset. Writes return RData=0.
- The Mem* outputs are 0 in IDLE and RESP.
- Reset during ACCESS forces MemWrite low before the next edge, so no memory write occurs. No Done is issued for the aborted request; the requester must re-request.

Test Plan:
- Port 0 writes 0x1234 at Addr 2; 2 cycles later port 1 reads Addr 2 → MemWrite high for exactly 1 cycle, memory bytes [2]=0x12 and [3]=0x34, Done1 with RData1=0x1234 and Err1=0.
- Req0 and Req1 rise on the same edge after reset (both reads at Addr 0) → Gnt0 first and Done0 at cycle +2, then Gnt1 at cycle +4 (after IDLE) and Done1 at +5.
- Both Req held continuously for 4 transactions → grant order 0,1,0,1 with no Gnt overlap and Done spacing of 3 cycles.
- Port 1 writes 0xBEEF at Addr 127 (and separately reads Addr 0xFFFF) → MemWrite and MemRead never assert, Done1 with Err1=1 and RData1=0; a read at Addr 126 gives Err1=0.
- Port 0 writes 0xBEEF at Addr 4 and Reset pulses mid-ACCESS → all outputs go 0 immediately, memory [4:5] unchanged, no Done0, and FSM is in IDLE after Reset releases.
- Port 0 reads Addr 5 while changing Addr0 to 9 right after Gnt0 → MemAddress=5 throughout ACCESS and RData0 = bytes [5]:[6].
